ps2_key_event_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 94 +++++++++
 rtl/ps2_event_fifo.sv | 57 +++++
 rtl/ps2_key_event_decoder.sv | 176 +++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, types and scan-code to ASCII helper for the PS/2 key event decoder
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT
  } rx_state_t;

  // Scan-code set 2 to ASCII; letters follow upper_letters, digits follow shift.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic ext,
                                             input logic upper_letters, input logic shift);
    logic [7:0] letter;
    logic [7:0] digit;
    logic [7:0] digit_sh;
    logic [7:0] result;
    letter   = 8'h00;
    digit    = 8'h00;
    digit_sh = 8'h00;
    result   = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: letter = 8'h61;
        8'h32: letter = 8'h62;
        8'h21: letter = 8'h63;
        8'h23: letter = 8'h64;
        8'h24: letter = 8'h65;
        8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67;
        8'h33: letter = 8'h68;
        8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A;
        8'h42: letter = 8'h6B;
        8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D;
        8'h31: letter = 8'h6E;
        8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70;
        8'h15: letter = 8'h71;
        8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73;
        8'h2C: letter = 8'h74;
        8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76;
        8'h1D: letter = 8'h77;
        8'h22: letter = 8'h78;
        8'h35: letter = 8'h79;
        8'h1A: letter = 8'h7A;
        default: letter = 8'h00;
      endcase
      case (code)
        8'h16: begin digit = 8'h31; digit_sh = 8'h21; end
        8'h1E: begin digit = 8'h32; digit_sh = 8'h40; end
        8'h26: begin digit = 8'h33; digit_sh = 8'h23; end
        8'h25: begin digit = 8'h34; digit_sh = 8'h24; end
        8'h2E: begin digit = 8'h35; digit_sh = 8'h25; end
        8'h36: begin digit = 8'h36; digit_sh = 8'h5E; end
        8'h3D: begin digit = 8'h37; digit_sh = 8'h26; end
        8'h3E: begin digit = 8'h38; digit_sh = 8'h2A; end
        8'h46: begin digit = 8'h39; digit_sh = 8'h28; end
        8'h45: begin digit = 8'h30; digit_sh = 8'h29; end
        default: begin digit = 8'h00; digit_sh = 8'h00; end
      endcase
      if (letter != 8'h00) begin
        result = upper_letters ? (letter - 8'h20) : letter;
      end else if (digit != 8'h00) begin
        result = shift ? digit_sh : digit;
      end else if (code == 8'h29) begin
        result = 8'h20;
      end else if (code == 8'h5A) begin
        result = 8'h0D;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through event FIFO
module ps2_event_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 scan-code to key event decoder with event FIFO
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_WIDTH       = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  input  logic                 rx_overflow,
  output logic                 nextdata_n,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_brk,
  output logic                 ev_ext,
  output logic [7:0]           ev_code,
  output logic [7:0]           ev_ascii,
  output logic                 held_valid,
  output logic                 held_ext,
  output logic [7:0]           held_code,
  output logic                 shift,
  output logic                 caps,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic                 err,
  input  logic                 clr_err
);

  rx_state_t  state;
  rx_state_t  next_state;
  logic       latch;
  logic       pend_ext;
  logic       pend_brk;
  logic       lshift;
  logic       rshift;
  logic       ovf_q;
  logic       is_code;
  logic       is_make;
  logic       is_break;
  logic       matches_held;
  logic       is_repeat;
  logic       suppress;
  logic       do_push;
  logic       fifo_empty;
  logic       fifo_full;
  ps2_event_t new_event;
  ps2_event_t head;

  assign shift = lshift | rshift;

  // Byte handshake with the receiver: latch, pulse nextdata_n, then one dead cycle.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and pop-pulse decode; a full FIFO holds off the receiver.
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    nextdata_n = 1'b1;
    case (state)
      S_IDLE: begin
        if (rx_ready && !fifo_full) begin
          latch      = 1'b1;
          next_state = S_POP;
        end
      end
      S_POP: begin
        nextdata_n = 1'b0;
        next_state = S_WAIT;
      end
      S_WAIT:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Classify the latched byte and build the event word from the pending prefixes.
  always_comb begin
    is_code      = latch && (rx_data != PS2_EXT) && (rx_data != PS2_BRK) && (rx_data != PS2_PAUSE);
    is_make      = is_code && !pend_brk;
    is_break     = is_code && pend_brk;
    matches_held = held_valid && (held_ext == pend_ext) && (held_code == rx_data);
    is_repeat    = is_make && matches_held;
    suppress     = is_repeat && SUPPRESS_REPEAT;
    do_push      = is_code && !suppress;
    new_event.brk   = pend_brk;
    new_event.ext   = pend_ext;
    new_event.code  = rx_data;
    new_event.ascii = pend_brk ? 8'h00 : sc_to_ascii(rx_data, pend_ext, shift ^ caps, shift);
  end

  // Prefix tracking: E0/F0 accumulate in either order, E1 and real codes clear them.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (latch) begin
      if (rx_data == PS2_EXT) begin
        pend_ext <= 1'b1;
      end else if (rx_data == PS2_BRK) begin
        pend_brk <= 1'b1;
      end else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  // Held key, press counter and modifier state, updated alongside the event push.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
      press_cnt  <= '0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps       <= 1'b0;
    end else begin
      if (is_make && !is_repeat) begin
        held_valid <= 1'b1;
        held_ext   <= pend_ext;
        held_code  <= rx_data;
      end else if (is_break && matches_held) begin
        held_valid <= 1'b0;
      end
      if (is_make && !suppress) begin
        press_cnt <= press_cnt + CNT_WIDTH'(1);
      end
      if (is_code && !pend_ext) begin
        if (rx_data == SC_LSHIFT) lshift <= !pend_brk;
        if (rx_data == SC_RSHIFT) rshift <= !pend_brk;
        if ((rx_data == SC_CAPS) && is_make && !is_repeat) caps <= !caps;
      end
    end
  end

  // Sticky overflow error on the rising edge of rx_overflow; clearing wins.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      ovf_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      ovf_q <= rx_overflow;
      if (clr_err) begin
        err <= 1'b0;
      end else if (rx_overflow && !ovf_q) begin
        err <= 1'b1;
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rest  (rest),
    .push  (do_push),
    .din   (new_event),
    .pop   (ev_ready),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ev_valid = !fifo_empty;
  assign ev_brk   = head.brk;
  assign ev_ext   = head.ext;
  assign ev_code  = head.code;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - directed table-driven bench for ps2_key_event_decoder
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       rest;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overflow;
  logic       nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_brk;
  logic       ev_ext;
  logic [7:0] ev_code;
  logic [7:0] ev_ascii;
  logic       held_valid;
  logic       held_ext;
  logic [7:0] held_code;
  logic       shift;
  logic       caps;
  logic [7:0] press_cnt;
  logic       err;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b;
    bit         has_ev;
    bit         brk;
    bit         ext;
    logic [7:0] code;
    logic [7:0] ascii;
    bit         held_v;
    bit         held_e;
    bit         sh;
    bit         cp;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] cap_q[$];

  always #5 clk = ~clk;

  ps2_key_event_decoder #(
    .FIFO_DEPTH      (8),
    .CNT_WIDTH       (8),
    .SUPPRESS_REPEAT (1'b1)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .nextdata_n  (nextdata_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_brk      (ev_brk),
    .ev_ext      (ev_ext),
    .ev_code     (ev_code),
    .ev_ascii    (ev_ascii),
    .held_valid  (held_valid),
    .held_ext    (held_ext),
    .held_code   (held_code),
    .shift       (shift),
    .caps        (caps),
    .press_cnt   (press_cnt),
    .err         (err),
    .clr_err     (clr_err)
  );

  always @(negedge clk) begin
    if (rest && ev_valid && ev_ready) cap_q.push_back({ev_brk, ev_ext, ev_code, ev_ascii});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input bit has, input bit brk, input bit ext,
                     input logic [7:0] code, input logic [7:0] asc,
                     input bit hv, input bit he, input bit sh, input bit cp);
    vec_t v;
    v = '{b, has, brk, ext, code, asc, hv, he, sh, cp};
    vecs.push_back(v);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (!nextdata_n) ok = 1'b1;
    end
    rx_ready = 1'b0;
    check("byte_popped", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    check("nextdata_pulse_width", {31'd0, nextdata_n}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_nextdata_n"}, {31'd0, nextdata_n}, 32'd1);
    check({tag, "_ev_valid"},   {31'd0, ev_valid},   32'd0);
    check({tag, "_held_valid"}, {31'd0, held_valid}, 32'd0);
    check({tag, "_held_code"},  {24'd0, held_code},  32'd0);
    check({tag, "_shift"},      {31'd0, shift},      32'd0);
    check({tag, "_caps"},       {31'd0, caps},       32'd0);
    check({tag, "_press_cnt"},  {24'd0, press_cnt},  32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
  endtask

  initial begin
    logic [7:0]  full_codes[10];
    logic [7:0]  full_ascii[10];
    logic [17:0] got;
    bit          seen;

    // byte, has_ev, brk, ext, code, ascii, held_v, held_e, shift, caps
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h61, 1, 0, 0, 0);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h00, 0, 0, 0, 0);
    add(8'h12, 1, 0, 0, 8'h12, 8'h00, 1, 0, 1, 0);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h41, 1, 0, 1, 0);
    add(8'h1C, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    add(8'h1C, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h00, 0, 0, 1, 0);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(8'h12, 1, 1, 0, 8'h12, 8'h00, 0, 0, 0, 0);
    add(8'h58, 1, 0, 0, 8'h58, 8'h00, 1, 0, 0, 1);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'h58, 1, 1, 0, 8'h58, 8'h00, 0, 0, 0, 1);
    add(8'h16, 1, 0, 0, 8'h16, 8'h31, 1, 0, 0, 1);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h41, 1, 0, 0, 1);
    add(8'hE0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'h75, 1, 0, 1, 8'h75, 8'h00, 1, 1, 0, 1);
    add(8'hE0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1);
    add(8'h75, 1, 1, 1, 8'h75, 8'h00, 0, 1, 0, 1);
    add(8'h12, 1, 0, 0, 8'h12, 8'h00, 1, 0, 1, 1);
    add(8'h16, 1, 0, 0, 8'h16, 8'h21, 1, 0, 1, 1);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h61, 1, 0, 1, 1);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1);
    add(8'h12, 1, 1, 0, 8'h12, 8'h00, 1, 0, 0, 1);
    add(8'hE0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'hE1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'h29, 1, 0, 0, 8'h29, 8'h20, 1, 0, 0, 1);
    add(8'h5A, 1, 0, 0, 8'h5A, 8'h0D, 1, 0, 0, 1);
    add(8'hF0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'hE0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(8'h75, 1, 1, 1, 8'h75, 8'h00, 1, 0, 0, 1);

    full_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    full_ascii = '{8'h51, 8'h57, 8'h45, 8'h52, 8'h54, 8'h59, 8'h55, 8'h49, 8'h4F, 8'h50};

    rest        = 1'b0;
    rx_data     = 8'h00;
    rx_ready    = 1'b0;
    rx_overflow = 1'b0;
    ev_ready    = 1'b1;
    clr_err     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rest = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send_byte(vecs[i].b);
      if (vecs[i].has_ev) begin
        check($sformatf("v%0d_event_count", i), cap_q.size(), 32'd1);
        if (cap_q.size() > 0) begin
          got = cap_q.pop_front();
          check($sformatf("v%0d_event", i), {14'd0, got},
                {14'd0, vecs[i].brk, vecs[i].ext, vecs[i].code, vecs[i].ascii});
        end
      end else begin
        check($sformatf("v%0d_no_event", i), cap_q.size(), 32'd0);
      end
      check($sformatf("v%0d_held_valid", i), {31'd0, held_valid}, {31'd0, vecs[i].held_v});
      if (vecs[i].held_v) check($sformatf("v%0d_held_ext", i), {31'd0, held_ext}, {31'd0, vecs[i].held_e});
      check($sformatf("v%0d_shift", i), {31'd0, shift}, {31'd0, vecs[i].sh});
      check($sformatf("v%0d_caps", i), {31'd0, caps}, {31'd0, vecs[i].cp});
      cap_q.delete();
    end
    check("table_press_cnt", {24'd0, press_cnt}, 32'd12);
    check("table_held_code", {24'd0, held_code}, 32'h5A);

    // Fill the FIFO with consumer stalled, then show back-pressure and lossless drain.
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(full_codes[i]);
    check("full_head_valid", {31'd0, ev_valid}, 32'd1);
    check("full_head_code", {24'd0, ev_code}, 32'h15);
    rx_data  = full_codes[8];
    rx_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (!nextdata_n) seen = 1'b1;
    end
    check("full_backpressure", {31'd0, seen}, 32'd0);
    check("full_head_stable", {24'd0, ev_code}, 32'h15);
    ev_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (!nextdata_n) seen = 1'b1;
    end
    rx_ready = 1'b0;
    check("full_resume_pop", {31'd0, seen}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    send_byte(full_codes[9]);
    repeat (15) @(posedge clk);
    #1;
    check("drain_count", cap_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (cap_q.size() > 0) begin
        got = cap_q.pop_front();
        check($sformatf("drain_%0d", i), {14'd0, got}, {14'd0, 2'b00, full_codes[i], full_ascii[i]});
      end
    end
    check("drain_empty", {31'd0, ev_valid}, 32'd0);
    check("drain_press_cnt", {24'd0, press_cnt}, 32'd22);
    check("drain_held_code", {24'd0, held_code}, 32'h4D);

    // Sticky overflow error and clear priority.
    rx_overflow = 1'b1;
    @(posedge clk); #1;
    rx_overflow = 1'b0;
    check("err_set", {31'd0, err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("err_held", {31'd0, err}, 32'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    check("err_cleared", {31'd0, err}, 32'd0);
    rx_overflow = 1'b1;
    @(posedge clk); #1;
    check("err_clear_priority", {31'd0, err}, 32'd0);
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("err_level_no_set", {31'd0, err}, 32'd0);
    rx_overflow = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an E0 F0 sequence drops the prefixes.
    send_byte(8'hE0);
    send_byte(8'hF0);
    rest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("midreset");
    rest = 1'b1;
    cap_q.delete();
    @(posedge clk); #1;
    send_byte(8'h1C);
    check("midreset_event_count", cap_q.size(), 32'd1);
    if (cap_q.size() > 0) begin
      got = cap_q.pop_front();
      check("midreset_event", {14'd0, got}, {14'd0, 2'b00, 8'h1C, 8'h61});
    end
    check("midreset_press_cnt", {24'd0, press_cnt}, 32'd1);
    check("midreset_held_ext", {31'd0, held_ext}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
